alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Collects a three-byte command from a UART receiver and runs it through an
// external ALU:
//   - operand A
//   - operand B
//   - opcode
// It then hands the ALU result to a UART transmitter and waits for that
// transmission to finish.
//
// Each accepted byte is registered onto ld_data. In the following cycle the
// matching load strobe is asserted, so the external operand and opcode
// registers capture ld_data on that edge.
//
// Optional feature (macro CMD_TIMEOUT_EN):
//   An inter-byte timeout in S_WAIT_B / S_WAIT_OP abandons a partially
//   received command after TIMEOUT_CYCLES cycles of silence. Without the
//   macro, no counter is built and the FSM waits indefinitely.
//
// Parameters:
//   DATA_WIDTH     - width of rx_data, ld_data, alu_result and tx_data
//   TIMEOUT_CYCLES - inter-byte timeout in clk cycles (minimum 2)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   rx_data    in   received byte, qualified by rx_valid
//   rx_valid   in   one-cycle strobe, new byte on rx_data
//   alu_result in   combinational ALU output fed by the operand registers
//   tx_busy    in   transmitter busy
//   tx_done    in   one-cycle strobe, transmission finished
//   ld_data    out  registered byte for the operand/opcode registers
//   load_a     out  one-cycle load enable, operand A register
//   load_b     out  one-cycle load enable, operand B register
//   load_op    out  one-cycle load enable, opcode register
//   tx_data    out  latched ALU result for transmission
//   tx_start   out  one-cycle transmit request
//   busy       out  high whenever a command is in progress
//   cmd_done   out  one-cycle strobe after the transmission completes
//   rx_overrun out  sticky flag, a received byte was dropped
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  load_a,
    output logic                  load_b,
    output logic                  load_op,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    output logic                  busy,
    output logic                  cmd_done,
    output logic                  rx_overrun
);

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("alu_cmd_sequencer: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t                state_q,      state_d;
    logic [DATA_WIDTH-1:0] ld_data_q,    ld_data_d;
    logic [DATA_WIDTH-1:0] tx_data_q,    tx_data_d;
    logic                  load_a_q,     load_a_d;
    logic                  load_b_q,     load_b_d;
    logic                  load_op_q,    load_op_d;
    logic                  cmd_done_q,   cmd_done_d;
    logic                  rx_overrun_q, rx_overrun_d;
    logic                  expired;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        ld_data_d    = ld_data_q;
        tx_data_d    = tx_data_q;
        load_a_d     = 1'b0;
        load_b_d     = 1'b0;
        load_op_d    = 1'b0;
        cmd_done_d   = 1'b0;
        rx_overrun_d = rx_overrun_q;
        tx_start     = 1'b0;

        case (state_q)
            S_WAIT_A: begin
                if (rx_valid) begin
                    ld_data_d = rx_data;
                    load_a_d  = 1'b1;
                    state_d   = S_WAIT_B;
                end
            end

            S_WAIT_B: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_valid) begin
                    ld_data_d = rx_data;
                    load_b_d  = 1'b1;
                    state_d   = S_WAIT_OP;
                end else if (expired) begin
                    state_d = S_WAIT_A;
                end
            end

            S_WAIT_OP: begin
                // The opcode register only captures ld_data on the edge that
                // ends the load_op cycle. S_EXEC is therefore entered one
                // cycle later, so alu_result reflects the new opcode there.
                // A byte arriving during the load_op cycle has no slot left
                // and is dropped.
                if (load_op_q) begin
                    state_d = S_EXEC;
                    if (rx_valid) begin
                        rx_overrun_d = 1'b1;
                    end
                end else if (rx_valid) begin
                    ld_data_d = rx_data;
                    load_op_d = 1'b1;
                end else if (expired) begin
                    state_d = S_WAIT_A;
                end
            end

            S_EXEC: begin
                tx_data_d = alu_result;
                state_d   = S_SEND;
                if (rx_valid) begin
                    rx_overrun_d = 1'b1;
                end
            end

            S_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_WAIT_TX;
                end
                if (rx_valid) begin
                    rx_overrun_d = 1'b1;
                end
            end

            S_WAIT_TX: begin
                if (tx_done) begin
                    cmd_done_d = 1'b1;
                    state_d    = S_WAIT_A;
                end
                if (rx_valid) begin
                    rx_overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = S_WAIT_A;
            end
        endcase
    end

`ifdef CMD_TIMEOUT_EN
    // The count runs only while idling in an operand wait state. It restarts
    // from zero on any accepted byte or any state change.
    always_comb begin
        cnt_d = '0;
        if (((state_q == S_WAIT_B) || ((state_q == S_WAIT_OP) && !load_op_q)) &&
            !rx_valid && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_WAIT_A;
            ld_data_q    <= '0;
            tx_data_q    <= '0;
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
            load_op_q    <= 1'b0;
            cmd_done_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_data_q    <= ld_data_d;
            tx_data_q    <= tx_data_d;
            load_a_q     <= load_a_d;
            load_b_q     <= load_b_d;
            load_op_q    <= load_op_d;
            cmd_done_q   <= cmd_done_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign ld_data    = ld_data_q;
    assign tx_data    = tx_data_q;
    assign load_a     = load_a_q;
    assign load_b     = load_b_q;
    assign load_op    = load_op_q;
    assign cmd_done   = cmd_done_q;
    assign rx_overrun = rx_overrun_q;
    assign busy       = (state_q != S_WAIT_A);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Directed bench for alu_cmd_sequencer. The bench covers:
//   - the basic command flow and its cycle timing
//   - a long tx_busy hold before transmission
//   - a dropped byte while waiting for the transmitter
//   - reset in the middle of a command
//   - inter-byte waiting; under CMD_TIMEOUT_EN this is the timeout
//
// Cycle n is the interval after clock edge n. Outputs are sampled 1 time unit
// after the rising edge; inputs are driven at the same point.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] alu_result;
    logic          tx_busy;
    logic          tx_done;
    logic [DW-1:0] ld_data;
    logic          load_a, load_b, load_op;
    logic [DW-1:0] tx_data;
    logic          tx_start, busy, cmd_done, rx_overrun;

    int tests = 0;
    int fails = 0;
    int starts;

    alu_cmd_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .alu_result(alu_result),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .ld_data   (ld_data),
        .load_a    (load_a),
        .load_b    (load_b),
        .load_op   (load_op),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .busy      (busy),
        .cmd_done  (cmd_done),
        .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        rx_data    = '0;
        rx_valid   = 1'b0;
        alu_result = 8'h08;
        tx_busy    = 1'b0;
        tx_done    = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_busy",    busy,       0);
        check("rst_ld_data", ld_data,    0);
        check("rst_tx_data", tx_data,    0);
        check("rst_loads",   {load_a, load_b, load_op}, 0);
        check("rst_txstart", tx_start,   0);
        check("rst_done",    cmd_done,   0);
        check("rst_overrun", rx_overrun, 0);
        reset = 1'b1;
        tick();

        // Basic command: 05, 03, 20 on cycles 0, 10, 20
        send_byte(8'h05);                               // cycle 1
        check("c1_load_a",   load_a,  1);
        check("c1_load_bop", {load_b, load_op}, 0);
        check("c1_ld_data",  ld_data, 8'h05);
        check("c1_busy",     busy,    1);
        tick();                                         // cycle 2
        check("c2_load_a",   load_a,  0);
        check("c2_ld_hold",  ld_data, 8'h05);
        repeat (8) tick();                              // cycle 10
        send_byte(8'h03);                               // cycle 11
        check("c11_load_b",  load_b,  1);
        check("c11_other",   {load_a, load_op}, 0);
        check("c11_ld_data", ld_data, 8'h03);
        tick();
        repeat (8) tick();                              // cycle 20
        send_byte(8'h20);                               // cycle 21
        check("c21_load_op", load_op, 1);
        check("c21_other",   {load_a, load_b}, 0);
        check("c21_ld_data", ld_data, 8'h20);
        check("c21_txstart", tx_start, 0);
        tick();                                         // cycle 22
        check("c22_txstart", tx_start, 0);
        check("c22_load_op", load_op, 0);
        check("c22_busy",    busy,    1);
        tick();                                         // cycle 23
        check("c23_txstart", tx_start, 1);
        check("c23_tx_data", tx_data, 8'h08);
        alu_result = 8'h55;
        tick();                                         // cycle 24
        check("c24_txstart", tx_start, 0);
        check("c24_tx_hold", tx_data, 8'h08);
        repeat (3) tick();
        check("wtx_busy",    busy,     1);
        check("wtx_done",    cmd_done, 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("done_pulse",  cmd_done, 1);
        check("done_idle",   busy,     0);
        tick();
        check("done_clear",  cmd_done, 0);
        check("overrun_clr", rx_overrun, 0);

        // tx_busy held for 50 cycles in S_SEND; stray tx_done in S_SEND
        alu_result = 8'h3C;
        send_byte(8'h01);
        send_byte(8'h02);
        tx_busy = 1'b1;
        send_byte(8'h30);                               // load_op cycle
        check("b_ld_data",   ld_data, 8'h30);
        starts = 0;
        for (int i = 0; i < 51; i++) begin
            tx_done = (i == 10);
            tick();
            if (tx_start) starts++;
            if (i == 10) check("send_ign_done", cmd_done, 0);
        end
        tx_done = 1'b0;
        check("busy_nostart", starts,   0);
        check("send_busy",    busy,     1);
        tx_busy = 1'b0;
        #1;
        check("first_free",   tx_start, 1);
        tick();
        check("after_start",  tx_start, 0);
        check("b_tx_data",    tx_data,  8'h3C);

        // Byte while waiting for the transmitter is dropped
        send_byte(8'h7F);
        check("ovr_loads",    {load_a, load_b, load_op}, 0);
        check("ovr_ld_data",  ld_data,    8'h30);
        check("ovr_flag",     rx_overrun, 1);
        tick();
        check("ovr_loads2",   {load_a, load_b, load_op}, 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("b_done",       cmd_done,   1);
        check("ovr_sticky",   rx_overrun, 1);
        tick();

        // Reset during S_WAIT_OP
        send_byte(8'h44);
        send_byte(8'h55);
        check("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("arst_busy",    busy,       0);
        check("arst_ld_data", ld_data,    0);
        check("arst_tx_data", tx_data,    0);
        check("arst_loads",   {load_a, load_b, load_op}, 0);
        check("arst_flags",   {tx_start, cmd_done, rx_overrun}, 0);
        tick();
        check("arst_hold",    {busy, load_a, load_b, load_op, tx_start}, 0);
        reset = 1'b1;
        send_byte(8'h11);
        check("post_rst_a",   load_a,  1);
        check("post_rst_ld",  ld_data, 8'h11);
        check("post_rst_bsy", busy,    1);

`ifdef CMD_TIMEOUT_EN
        // Silence after operand A: 16 cycles in S_WAIT_B, then back to idle
        repeat (15) tick();
        check("to_busy16",    busy, 1);
        tick();
        check("to_idle",      busy, 0);
        check("to_noload",    {load_a, load_b, load_op}, 0);
        send_byte(8'h22);
        check("to_next_a",    load_a,  1);
        check("to_next_ld",   ld_data, 8'h22);
        repeat (15) tick();                             // expiry cycle
        send_byte(8'h23);
        check("to_prio_b",    load_b,  1);
        check("to_prio_ld",   ld_data, 8'h23);
        check("to_prio_busy", busy,    1);
`else
        // No timeout: the FSM keeps waiting for operand B
        repeat (40) tick();
        check("nto_busy",     busy, 1);
        check("nto_noload",   {load_a, load_b, load_op}, 0);
        send_byte(8'h23);
        check("nto_load_b",   load_b,  1);
        check("nto_ld",       ld_data, 8'h23);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
